// File: rtl/ain_debounce.sv
// Input conditioner for the FSM ain bus: synchronises raw_in, debounces the
// vector as a whole, strobes on commit and counts aborted qualifications.
module ain_debounce #(
   parameter int               WIDTH       = 2,
   parameter int               SYNC_STAGES = 2,
   parameter int               DB_CYCLES   = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter int               GCNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  raw_in,
   output logic [WIDTH-1:0]  ain,
   output logic              ain_changed,
   output logic              busy,
   output logic [GCNT_W-1:0] glitch_cnt
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   typedef enum logic {
      IDLE,
      QUALIFY
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] syn;
   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= raw_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign syn  = sync_q[SYNC_STAGES-1];
   assign busy = (state == QUALIFY);

   // Any abort while qualifying counts as one glitch, whether the input
   // bounced back to ain or moved on to yet another code.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ain         <= RESET_VAL;
         cand        <= RESET_VAL;
         cnt         <= '0;
         ain_changed <= 1'b0;
         glitch_cnt  <= '0;
      end else begin
         ain_changed <= 1'b0;
         unique case (state)
            IDLE: begin
               if (syn != ain) begin
                  cand  <= syn;
                  cnt   <= CW'(1);
                  state <= QUALIFY;
               end
            end
            QUALIFY: begin
               if (syn == cand) begin
                  if (cnt == CW'(DB_CYCLES)) begin
                     ain         <= cand;
                     ain_changed <= 1'b1;
                     cnt         <= '0;
                     state       <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  if (glitch_cnt != '1) begin
                     glitch_cnt <= glitch_cnt + GCNT_W'(1);
                  end
                  if (syn == ain) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cand <= syn;
                     cnt  <= CW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ain_debounce.sv
// Bench for ain_debounce: directed scenarios plus random hold-time stimulus
// against a run-length reference model; a second DUT has a 2-bit glitch count.
module tb_ain_debounce;

   localparam int S  = 2;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] raw_in = 2'b00;

   logic [1:0] ain, ain_b;
   logic       ain_changed, chg_b;
   logic       busy, busy_b;
   logic [7:0] glitch_cnt;
   logic [1:0] gcnt_b;

   ain_debounce #(.GCNT_W(8)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .ain(ain), .ain_changed(ain_changed),
      .busy(busy), .glitch_cnt(glitch_cnt)
   );

   ain_debounce #(.GCNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .ain(ain_b), .ain_changed(chg_b),
      .busy(busy_b), .glitch_cnt(gcnt_b)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: syn is raw delayed S edges; a value commits once it has
   // been seen for DB+1 consecutive edges while differing from ain.
   logic [1:0] m_sy [S];
   logic [1:0] m_ain, m_last;
   int         m_run, m_gl;
   bit         m_busy, m_chg;

   task automatic model_step(input bit rst, input logic [1:0] raw);
      logic [1:0] syn;
      if (rst) begin
         for (int i = 0; i < S; i++) m_sy[i] = 2'b00;
         m_ain  = 2'b00;
         m_last = 2'b00;
         m_run  = 1;
         m_gl   = 0;
         m_busy = 0;
         m_chg  = 0;
      end else begin
         syn = m_sy[S-1];
         if (syn == m_last) m_run++;
         else m_run = 1;
         if (m_busy && syn != m_last) m_gl++;
         m_chg = 0;
         if (syn != m_ain && m_run >= DB + 1) begin
            m_ain = syn;
            m_chg = 1;
         end
         m_last = syn;
         m_busy = (syn != m_ain);
         for (int i = S - 1; i > 0; i--) m_sy[i] = m_sy[i-1];
         m_sy[0] = raw;
      end
   endtask

   task automatic cyc(input bit rst, input logic [1:0] r);
      @(negedge clk);
      reset  = rst;
      raw_in = r;
      @(posedge clk);
      model_step(rst, r);
      #1;
      check("ain", ain, m_ain);
      check("ain_changed", ain_changed, m_chg);
      check("busy", busy, m_busy);
      check("glitch_cnt", glitch_cnt, (m_gl > 255) ? 255 : m_gl);
      check("ain_b", ain_b, m_ain);
      check("chg_b", chg_b, m_chg);
      check("busy_b", busy_b, m_busy);
      check("gcnt_b", gcnt_b, (m_gl > 3) ? 3 : m_gl);
   endtask

   int  lat, pulses;
   bit  saw_busy, saw01;
   int  hold;
   logic [1:0] v;

   initial begin
      // 1 reset and hold
      cyc(1'b1, 2'b00);
      cyc(1'b1, 2'b00);
      for (int i = 0; i < 20; i++) cyc(1'b0, 2'b00);
      check("t1_ain", ain, 2'b00);
      check("t1_gcnt", glitch_cnt, 0);

      // 2 clean step
      lat = -1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 2'b11);
         if (ain_changed) pulses++;
         if (lat < 0 && ain == 2'b11) lat = i;
      end
      check("t2_latency", lat, 6);
      check("t2_pulses", pulses, 1);
      check("t2_gcnt", glitch_cnt, 0);

      // 3 bounce
      cyc(1'b1, 2'b00);
      saw_busy = 0;
      cyc(1'b0, 2'b11);
      cyc(1'b0, 2'b11);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 2'b00);
         if (busy) saw_busy = 1;
      end
      check("t3_ain", ain, 2'b00);
      check("t3_busy_seen", saw_busy, 1);
      check("t3_gcnt", glitch_cnt, 1);

      // 4 skew
      cyc(1'b1, 2'b00);
      pulses = 0;
      saw01 = 0;
      cyc(1'b0, 2'b01);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 2'b11);
         if (ain_changed) pulses++;
         if (ain == 2'b01) saw01 = 1;
      end
      check("t4_ain", ain, 2'b11);
      check("t4_saw01", saw01, 0);
      check("t4_gcnt", glitch_cnt, 1);
      check("t4_pulses", pulses, 1);

      // 5 reset mid-qualify
      cyc(1'b1, 2'b00);
      for (int i = 0; i < 4; i++) cyc(1'b0, 2'b10);
      cyc(1'b1, 2'b10);
      check("t5_ain", ain, 2'b00);
      check("t5_busy", busy, 0);
      lat = -1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 2'b10);
         if (lat < 0 && ain == 2'b10) lat = i;
      end
      check("t5_latency", lat, 6);
      check("t5_gcnt", glitch_cnt, 0);

      // 6 saturation
      cyc(1'b1, 2'b00);
      for (int n = 0; n < 5; n++) begin
         cyc(1'b0, 2'b11);
         cyc(1'b0, 2'b11);
         for (int i = 0; i < 6; i++) cyc(1'b0, 2'b00);
      end
      for (int i = 0; i < 10; i++) cyc(1'b0, 2'b00);
      check("t6_gcnt_sat", gcnt_b, 3);
      check("t6_gcnt_wide", glitch_cnt, 5);
      check("t6_ain", ain_b, 2'b00);

      // random holds, occasional reset
      for (int n = 0; n < 1500; n++) begin
         v = 2'($urandom_range(0, 3));
         hold = $urandom_range(1, 8);
         if ($urandom_range(0, 99) == 0) cyc(1'b1, v);
         for (int i = 0; i < hold; i++) cyc(1'b0, v);
      end

      $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
      $finish;
   end

endmodule
